// File: rtl/lia_pkg.sv
// Shared types and helpers for the lock-in amplifier DC-offset calibration path.
package lia_pkg;

    // Default sample width of the demodulated channels.
    localparam int unsigned LIA_DW = 16;

    // Calibration sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StAccum,
        StLatch,
        StTrack
    } cal_state_t;

    // Signed a - b, clamped to the range of a w-bit two's complement value (w <= 31).
    // The difference is formed at 33 bits so it can never wrap before clamping.
    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [32:0] diff;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        diff = 33'(a) - 33'(b);
        hi   = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo   = -(33'sd1 <<< (w - 1));
        if (diff > hi) begin
            diff = hi;
        end else if (diff < lo) begin
            diff = lo;
        end
        return diff[31:0];
    endfunction

endpackage

// File: rtl/dc_accum_channel.sv
// One channel of the offset calibrator: sample accumulator, latched offset and the
// saturating offset-corrected output register.
module dc_accum_channel
    import lia_pkg::*;
#(
    parameter int unsigned DW       = LIA_DW,
    parameter int unsigned LOG2_AVG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          acc_en,
    input  logic          latch,
    input  logic          in_valid,
    input  logic [DW-1:0] in_x,
    output logic [DW-1:0] off,
    output logic [DW-1:0] corr
);

    // Wide enough for 2^LOG2_AVG full-scale samples, so the sum never overflows.
    localparam int unsigned AW = DW + LOG2_AVG;

    logic [AW-1:0] acc_q;

    // Accumulate sign-extended samples; on latch take the floor average as the offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            off   <= '0;
        end else if (clr) begin
            acc_q <= '0;
            off   <= '0;
        end else begin
            if (acc_en) begin
                acc_q <= acc_q + AW'($signed(in_x));
            end
            if (latch) begin
                // Arithmetic shift: rounds toward minus infinity.
                off <= DW'($signed(acc_q) >>> LOG2_AVG);
            end
        end
    end

    // Correction path runs in every state, using whatever offset is currently held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr <= '0;
        end else if (in_valid) begin
            corr <= DW'(sat_sub(32'($signed(in_x)), 32'($signed(off)), DW));
        end
    end

endmodule

// File: rtl/dc_offset_calibrator.sv
// DC-offset calibration sequencer for the four demodulated LIA channels
// (0.5f sin/cos, 6f sin/cos). After start it waits a settling interval, averages
// 2^LOG2_AVG valid samples per channel, latches the averages as offsets and then
// streams offset-corrected, saturated samples.
module dc_offset_calibrator
    import lia_pkg::*;
#(
    parameter int unsigned DW            = LIA_DW,
    parameter int unsigned SETTLE_CYCLES = 40960,
    parameter int unsigned LOG2_AVG      = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_05sin,
    input  logic [DW-1:0] in_05cos,
    input  logic [DW-1:0] in_6sin,
    input  logic [DW-1:0] in_6cos,
    output logic [DW-1:0] off_05sin,
    output logic [DW-1:0] off_05cos,
    output logic [DW-1:0] off_6sin,
    output logic [DW-1:0] off_6cos,
    output logic [DW-1:0] corr_05sin,
    output logic [DW-1:0] corr_05cos,
    output logic [DW-1:0] corr_6sin,
    output logic [DW-1:0] corr_6cos,
    output logic          out_valid,
    output logic          busy,
    output logic          cal_done
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    cal_state_t          state_q;
    logic [CNT_W-1:0]    settle_cnt_q;
    logic [LOG2_AVG-1:0] samp_cnt_q;

    logic clr;
    logic acc_en;
    logic latch;

    // Channel controls; start outranks everything, so a sample coinciding with it is dropped.
    always_comb begin
        clr    = start;
        acc_en = (state_q == StAccum) && in_valid && !start;
        latch  = (state_q == StLatch) && !start;
    end

    // Sequencer: state, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            busy         <= 1'b0;
            cal_done     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (start) begin
                state_q      <= StSettle;
                settle_cnt_q <= '0;
                samp_cnt_q   <= '0;
                busy         <= 1'b1;
                cal_done     <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                    end
                    StSettle: begin
                        // Counter runs 0..SETTLE_CYCLES, i.e. SETTLE_CYCLES+1 cycles here.
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= StAccum;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    StAccum: begin
                        if (in_valid) begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                            if (samp_cnt_q == {LOG2_AVG{1'b1}}) begin
                                state_q <= StLatch;
                            end
                        end
                    end
                    StLatch: begin
                        state_q  <= StTrack;
                        busy     <= 1'b0;
                        cal_done <= 1'b1;
                    end
                    StTrack: begin
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    dc_accum_channel #(
        .DW       (DW),
        .LOG2_AVG (LOG2_AVG)
    ) u_ch_05sin (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc_en   (acc_en),
        .latch    (latch),
        .in_valid (in_valid),
        .in_x     (in_05sin),
        .off      (off_05sin),
        .corr     (corr_05sin)
    );

    dc_accum_channel #(
        .DW       (DW),
        .LOG2_AVG (LOG2_AVG)
    ) u_ch_05cos (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc_en   (acc_en),
        .latch    (latch),
        .in_valid (in_valid),
        .in_x     (in_05cos),
        .off      (off_05cos),
        .corr     (corr_05cos)
    );

    dc_accum_channel #(
        .DW       (DW),
        .LOG2_AVG (LOG2_AVG)
    ) u_ch_6sin (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc_en   (acc_en),
        .latch    (latch),
        .in_valid (in_valid),
        .in_x     (in_6sin),
        .off      (off_6sin),
        .corr     (corr_6sin)
    );

    dc_accum_channel #(
        .DW       (DW),
        .LOG2_AVG (LOG2_AVG)
    ) u_ch_6cos (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc_en   (acc_en),
        .latch    (latch),
        .in_valid (in_valid),
        .in_x     (in_6cos),
        .off      (off_6cos),
        .corr     (corr_6cos)
    );

endmodule

// File: tb/tb_dc_offset_calibrator.sv
// Directed bench for dc_offset_calibrator with a short settle (16) and 4-sample averaging.
module tb_dc_offset_calibrator;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_05sin = '0;
    logic [DW-1:0] in_05cos = '0;
    logic [DW-1:0] in_6sin = '0;
    logic [DW-1:0] in_6cos = '0;
    logic [DW-1:0] off_05sin, off_05cos, off_6sin, off_6cos;
    logic [DW-1:0] corr_05sin, corr_05cos, corr_6sin, corr_6cos;
    logic          out_valid, busy, cal_done;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;

    dc_offset_calibrator #(
        .DW            (DW),
        .SETTLE_CYCLES (16),
        .LOG2_AVG      (2),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_05sin   (in_05sin),
        .in_05cos   (in_05cos),
        .in_6sin    (in_6sin),
        .in_6cos    (in_6cos),
        .off_05sin  (off_05sin),
        .off_05cos  (off_05cos),
        .off_6sin   (off_6sin),
        .off_6cos   (off_6cos),
        .corr_05sin (corr_05sin),
        .corr_05cos (corr_05cos),
        .corr_6sin  (corr_6sin),
        .corr_6cos  (corr_6cos),
        .out_valid  (out_valid),
        .busy       (busy),
        .cal_done   (cal_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        in_05sin = 16'(v);
        in_05cos = 16'(v);
        in_6sin  = 16'(v);
        in_6cos  = 16'(v);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_offs(input string tag, input int v);
        chk({tag, "_off_05sin"}, $signed(off_05sin), v);
        chk({tag, "_off_05cos"}, $signed(off_05cos), v);
        chk({tag, "_off_6sin"},  $signed(off_6sin),  v);
        chk({tag, "_off_6cos"},  $signed(off_6cos),  v);
    endtask

    initial begin
        // Reset state while rst is held
        #12;
        chk_offs("rst", 0);
        chk("rst_corr_6sin", $signed(corr_6sin), 0);
        chk("rst_busy", busy, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        tick();

        // Constant 100 on all channels, valid every cycle
        set_all(100);
        in_valid = 1'b1;
        pulse_start();
        chk_offs("settle", 0);
        busy_cycles = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            busy_cycles++;
            tick();
        end
        chk("busy_cycles", busy_cycles, 22);
        chk("const_cal_done", cal_done, 1);
        chk_offs("const", 100);
        tick();
        chk("const_corr_05sin", $signed(corr_05sin), 0);
        chk("const_corr_05cos", $signed(corr_05cos), 0);
        chk("const_corr_6sin", $signed(corr_6sin), 0);
        chk("const_corr_6cos", $signed(corr_6cos), 0);
        chk("const_out_valid", out_valid, 1);

        // Negative saturation with off = 100, plus an ordinary subtraction
        in_05sin = 16'd150;
        in_6sin  = 16'h8000;
        tick();
        chk("sub_corr_05sin", $signed(corr_05sin), 50);
        chk("satneg_corr_6sin", $signed(corr_6sin), -32768);

        // No valid: correction holds, out_valid drops
        in_valid = 1'b0;
        in_05sin = 16'd7;
        tick();
        chk("hold_corr_05sin", $signed(corr_05sin), 50);
        chk("hold_out_valid", out_valid, 0);

        // Floor averaging: -1,-2,-2,-2 sums to -7, >>> 2 gives -2
        pulse_start();
        chk("floor_busy", busy, 1);
        chk("floor_cal_done_clr", cal_done, 0);
        chk("floor_off_clr", $signed(off_05sin), 0);
        repeat (17) tick();
        in_05cos = 16'd7;
        in_6sin  = -16'sd100;
        in_6cos  = 16'd0;
        in_valid = 1'b1;
        in_05sin = -16'sd1;
        tick();
        in_05sin = -16'sd2;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        chk("floor_cal_done", cal_done, 1);
        chk("floor_busy_low", busy, 0);
        chk("floor_off_05sin", $signed(off_05sin), -2);
        chk("floor_off_05cos", $signed(off_05cos), 7);
        chk("floor_off_6sin", $signed(off_6sin), -100);
        chk("floor_off_6cos", $signed(off_6cos), 0);

        // Positive saturation with off = -100
        in_6sin  = 16'd32760;
        in_05sin = 16'h8000;
        in_valid = 1'b1;
        tick();
        chk("satpos_corr_6sin", $signed(corr_6sin), 32767);
        chk("nosat_corr_05sin", $signed(corr_05sin), -32766);

        // Asynchronous reset mid-TRACK
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_offs("arst", 0);
        chk("arst_corr_6sin", $signed(corr_6sin), 0);
        chk("arst_corr_05sin", $signed(corr_05sin), 0);
        chk("arst_busy", busy, 0);
        chk("arst_cal_done", cal_done, 0);
        tick();
        rst = 1'b0;
        tick();

        // Restart after two ACCUM samples; only post-restart samples count
        set_all(1000);
        in_valid = 1'b1;
        pulse_start();
        repeat (17) tick();
        repeat (2) tick();
        pulse_start();
        chk("restart_busy", busy, 1);
        chk("restart_cal_done", cal_done, 0);
        chk_offs("restart_clr", 0);
        in_valid = 1'b0;
        repeat (17) tick();
        in_valid = 1'b1;
        set_all(40);
        repeat (2) tick();
        set_all(44);
        repeat (2) tick();
        in_valid = 1'b0;
        tick();
        chk("restart_done", cal_done, 1);
        chk_offs("restart", 42);

        // Valid pulses during SETTLE are ignored
        set_all(5000);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            in_valid = (i % 2 == 0);
            tick();
        end
        set_all(100);
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        tick();
        chk("ign_cal_done", cal_done, 1);
        chk_offs("ign", 100);

        // Start coincident with the 4th ACCUM sample restarts the sequence
        pulse_start();
        repeat (17) tick();
        in_valid = 1'b1;
        repeat (3) tick();
        pulse_start();
        in_valid = 1'b0;
        chk("coinc_busy", busy, 1);
        chk("coinc_cal_done", cal_done, 0);
        chk_offs("coinc", 0);
        repeat (3) tick();
        chk("coinc_cal_done_later", cal_done, 0);
        chk("coinc_busy_later", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
